i2c_bus_recovery: RTL and testbench

Bus-health monitor and recovery sequencer for the CPLD I2C port, sitting directly upstream of the general `timer` block. It drives that timer's enable, delay and clock-enable inputs and consumes its `timeout`. It flags SCL held low, and clears SDA held low by clocking up to 9 SCL pulses followed by a STOP.

---
 rtl/i2c_bus_recovery_pkg.sv | 51 +++++
 rtl/i2c_bus_recovery_if.sv | 23 ++
 rtl/i2c_bus_recovery_tick_gen.sv | 27 ++
 rtl/i2c_bus_recovery.sv | 159 +++++++++++++++
 tb/tb_i2c_bus_recovery.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_bus_recovery_pkg.sv
// Shared types and constants for the I2C bus-recovery sequencer.
package i2c_bus_recovery_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StSclChk,
      StSclStuck,
      StSdaChk,
      StPLo,
      StPHi,
      StStLo,
      StStSu,
      StStRel,
      StFail
   } state_t;

   // Which delay a state loads into the external timer.
   typedef enum logic [1:0] {
      DlyNone,
      DlyStuck,
      DlyHalf
   } dly_sel_t;

   localparam int unsigned REC_MAX_PULSES = 9;
   localparam dly_sel_t    SCL_STUCK_SEL  = DlyStuck;
   localparam dly_sel_t    REC_DLY_SEL    = DlyHalf;

   function automatic dly_sel_t dly_sel(input state_t st);
      dly_sel_t sel;
      unique case (st)
         StSclChk, StSdaChk:                     sel = SCL_STUCK_SEL;
         StPLo, StPHi, StStLo, StStSu, StStRel:  sel = REC_DLY_SEL;
         default:                                sel = DlyNone;
      endcase
      return sel;
   endfunction

   function automatic logic drives_scl(input state_t st);
      return (st == StPLo) || (st == StStLo);
   endfunction

   function automatic logic drives_sda(input state_t st);
      return (st == StStLo) || (st == StStSu);
   endfunction

   function automatic logic in_recovery(input state_t st);
      return (st == StPLo) || (st == StPHi) || (st == StStLo) || (st == StStSu) ||
             (st == StStRel);
   endfunction

endpackage

// File: rtl/i2c_bus_recovery_if.sv
// Bus lines and timer link between the recovery sequencer and its environment.
interface i2c_bus_recovery_if #(
   parameter int unsigned SIZE = 5
);
   logic            scl_in;
   logic            sda_in;
   logic            scl_oe;
   logic            sda_oe;
   logic            tmr_clk_en;
   logic            tmr_en;
   logic [SIZE-1:0] tmr_dly;
   logic            tmr_timeout;

   modport master (
      input  scl_in, sda_in, tmr_timeout,
      output scl_oe, sda_oe, tmr_clk_en, tmr_en, tmr_dly
   );

   modport slave (
      output scl_in, sda_in, tmr_timeout,
      input  scl_oe, sda_oe, tmr_clk_en, tmr_en, tmr_dly
   );
endinterface

// File: rtl/i2c_bus_recovery_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module i2c_bus_recovery_tick_gen #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // Count 0..TICK_DIV-1 and register the wrap as the tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_cnt == LAST);
         r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = r_tick;
endmodule

// File: rtl/i2c_bus_recovery.sv
// I2C bus-health monitor: flags SCL stuck low and clocks SDA free with up to
// 9 SCL pulses followed by a STOP. Drives an external timer.
module i2c_bus_recovery
   import i2c_bus_recovery_pkg::*;
#(
   parameter int unsigned SIZE      = 5,
   parameter int unsigned TICK_DIV  = 50,
   parameter int unsigned STUCK_DLY = 25,
   parameter int unsigned HALF_DLY  = 4
) (
   input  logic               i_cpld_50m_clk,
   input  logic               i_cpld_rst_n_50m,
   input  logic               i_mon_en,
   input  logic               i_clr_fail,
   i2c_bus_recovery_if.master bus_if,
   output logic               o_scl_stuck,
   output logic               o_rec_busy,
   output logic               o_rec_done,
   output logic               o_rec_fail,
   output logic [3:0]         o_pulse_cnt
);
   localparam logic [SIZE-1:0] STUCK_VAL = SIZE'(STUCK_DLY);
   localparam logic [SIZE-1:0] HALF_VAL  = SIZE'(HALF_DLY);

   logic            r_scl_meta, r_scl_s, r_sda_meta, r_sda_s;
   state_t          r_state, w_nxt;
   logic            r_tmr_en;
   logic [SIZE-1:0] r_tmr_dly;
   logic            r_scl_oe, r_sda_oe;
   logic            r_scl_stuck, r_rec_busy, r_rec_done, r_rec_fail;
   logic [3:0]      r_pulse_cnt;
   logic            w_tmo, w_cnt_clr, w_cnt_inc, w_done, w_tick;

   i2c_bus_recovery_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .i_clk   (i_cpld_50m_clk),
      .i_rst_n (i_cpld_rst_n_50m),
      .o_tick  (w_tick)
   );

   // Two-flop synchronizers; idle bus level is high.
   always_ff @(posedge i_cpld_50m_clk or negedge i_cpld_rst_n_50m) begin
      if (!i_cpld_rst_n_50m) begin
         r_scl_meta <= 1'b1;
         r_scl_s    <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_s    <= 1'b1;
      end else begin
         r_scl_meta <= bus_if.scl_in;
         r_scl_s    <= r_scl_meta;
         r_sda_meta <= bus_if.sda_in;
         r_sda_s    <= r_sda_meta;
      end
   end

   // Timeout is ignored in a state's first clock: the timer still shows the
   // previous state's timeout until it sees the restart low.
   assign w_tmo = bus_if.tmr_timeout & r_tmr_en;

   // Next-state decode plus the event strobes that accompany transitions.
   always_comb begin
      w_nxt     = r_state;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_done    = 1'b0;
      if (!i_mon_en) begin
         w_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (!r_scl_s)      w_nxt = StSclChk;
               else if (!r_sda_s) w_nxt = StSdaChk;
            end
            StSclChk: begin
               if (r_scl_s)    w_nxt = StIdle;
               else if (w_tmo) w_nxt = StSclStuck;
            end
            StSclStuck: if (r_scl_s) w_nxt = StIdle;
            StSdaChk: begin
               if (r_sda_s || !r_scl_s) begin
                  w_nxt = StIdle;
               end else if (w_tmo && !r_rec_fail) begin
                  w_nxt     = StPLo;
                  w_cnt_clr = 1'b1;
               end
            end
            StPLo: begin
               if (w_tmo) begin
                  w_nxt     = StPHi;
                  w_cnt_inc = 1'b1;
               end
            end
            StPHi: begin
               if (w_tmo) begin
                  if (r_sda_s)                                  w_nxt = StStLo;
                  else if (r_pulse_cnt == 4'(REC_MAX_PULSES))   w_nxt = StFail;
                  else                                          w_nxt = StPLo;
               end
            end
            StStLo: if (w_tmo) w_nxt = StStSu;
            StStSu: if (w_tmo) w_nxt = StStRel;
            StStRel: begin
               if (w_tmo) begin
                  w_nxt  = StIdle;
                  w_done = 1'b1;
               end
            end
            StFail:  w_nxt = StIdle;
            default: w_nxt = StIdle;
         endcase
      end
   end

   // State register with all outputs registered from the next state.
   always_ff @(posedge i_cpld_50m_clk or negedge i_cpld_rst_n_50m) begin
      if (!i_cpld_rst_n_50m) begin
         r_state     <= StIdle;
         r_tmr_en    <= 1'b0;
         r_tmr_dly   <= '0;
         r_scl_oe    <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_scl_stuck <= 1'b0;
         r_rec_busy  <= 1'b0;
         r_rec_done  <= 1'b0;
         r_rec_fail  <= 1'b0;
         r_pulse_cnt <= '0;
      end else begin
         r_state <= w_nxt;
         // Low on the entry clock of every timed state clears the timer.
         r_tmr_en <= (dly_sel(w_nxt) != DlyNone) && (w_nxt == r_state);
         unique case (dly_sel(w_nxt))
            DlyStuck: r_tmr_dly <= STUCK_VAL;
            DlyHalf:  r_tmr_dly <= HALF_VAL;
            default:  r_tmr_dly <= '0;
         endcase
         r_scl_oe    <= drives_scl(w_nxt);
         r_sda_oe    <= drives_sda(w_nxt);
         r_scl_stuck <= (w_nxt == StSclStuck);
         r_rec_busy  <= in_recovery(w_nxt);
         r_rec_done  <= w_done;
         // FAIL entry beats a simultaneous clear.
         r_rec_fail  <= (w_nxt == StFail) | (r_rec_fail & ~i_clr_fail);
         if (w_cnt_clr)      r_pulse_cnt <= '0;
         else if (w_cnt_inc) r_pulse_cnt <= r_pulse_cnt + 4'd1;
      end
   end

   assign bus_if.scl_oe     = r_scl_oe;
   assign bus_if.sda_oe     = r_sda_oe;
   assign bus_if.tmr_clk_en = w_tick;
   assign bus_if.tmr_en     = r_tmr_en;
   assign bus_if.tmr_dly    = r_tmr_dly;
   assign o_scl_stuck       = r_scl_stuck;
   assign o_rec_busy        = r_rec_busy;
   assign o_rec_done        = r_rec_done;
   assign o_rec_fail        = r_rec_fail;
   assign o_pulse_cnt       = r_pulse_cnt;
endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Self-checking bench for i2c_bus_recovery with a behavioural timer and
// open-drain bus model.
module tb_i2c_bus_recovery;
   localparam int unsigned SIZE  = 5;
   localparam int unsigned TICK  = 50;
   localparam int unsigned STUCK = 25;
   localparam int unsigned HALF  = 4;

   logic clk      = 1'b0;
   logic rst_n    = 1'b1;
   logic mon_en   = 1'b0;
   logic clr_fail = 1'b0;
   logic scl_ext  = 1'b1;
   logic sda_ext  = 1'b1;

   logic       scl_stuck, rec_busy, rec_done, rec_fail;
   logic [3:0] pulse_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   i2c_bus_recovery_if #(.SIZE(SIZE)) bus_if ();

   i2c_bus_recovery #(
      .SIZE      (SIZE),
      .TICK_DIV  (TICK),
      .STUCK_DLY (STUCK),
      .HALF_DLY  (HALF)
   ) dut (
      .i_cpld_50m_clk   (clk),
      .i_cpld_rst_n_50m (rst_n),
      .i_mon_en         (mon_en),
      .i_clr_fail       (clr_fail),
      .bus_if           (bus_if),
      .o_scl_stuck      (scl_stuck),
      .o_rec_busy       (rec_busy),
      .o_rec_done       (rec_done),
      .o_rec_fail       (rec_fail),
      .o_pulse_cnt      (pulse_cnt)
   );

   always #5 clk = ~clk;

   // Wired-AND open-drain bus.
   assign bus_if.scl_in = scl_ext & ~bus_if.scl_oe;
   assign bus_if.sda_in = sda_ext & ~bus_if.sda_oe;

   // Behavioural timer: cleared while disabled, timeout after dly+1 ticks.
   int unsigned t_cnt = 0;
   logic        t_tmo = 1'b0;
   always @(posedge clk) begin
      if (!bus_if.tmr_en) begin
         t_cnt <= 0;
         t_tmo <= 1'b0;
      end else if (bus_if.tmr_clk_en) begin
         if (t_cnt >= 32'(bus_if.tmr_dly)) t_tmo <= 1'b1;
         else                              t_cnt <= t_cnt + 1;
      end
   end
   assign bus_if.tmr_timeout = t_tmo;

   // Event counters (monotonic; the main sequence works on deltas).
   int n_scl_pulse = 0, n_sda_pulse = 0, n_done = 0, n_busy_gap = 0;
   int n_en_long = 0, n_w_bad = 0, n_busy_rise = 0, n_stuck_rise = 0;
   int w_cur = 0;
   logic            p_scl_oe = 1'b0, p_sda_oe = 1'b0, p_en = 1'b0;
   logic            p_busy = 1'b0, p_stuck = 1'b0;
   logic [SIZE-1:0] p_dly = '0;
   always @(negedge clk) begin
      if (bus_if.scl_oe && !p_scl_oe) n_scl_pulse++;
      if (bus_if.scl_oe) begin
         w_cur++;
      end else if (p_scl_oe) begin
         if (w_cur < int'(HALF * TICK) || w_cur > int'((HALF + 1) * TICK + 3)) n_w_bad++;
         w_cur = 0;
      end
      if (bus_if.sda_oe && !p_sda_oe) n_sda_pulse++;
      if (rec_done) n_done++;
      if (rec_busy && !bus_if.tmr_en) n_busy_gap++;
      // Two consecutive low clocks inside timed states break the restart rule.
      if (!bus_if.tmr_en && !p_en && bus_if.tmr_dly != 0 && p_dly != 0) n_en_long++;
      if (rec_busy && !p_busy) n_busy_rise++;
      if (scl_stuck && !p_stuck) n_stuck_rise++;
      p_scl_oe = bus_if.scl_oe;
      p_sda_oe = bus_if.sda_oe;
      p_en     = bus_if.tmr_en;
      p_dly    = bus_if.tmr_dly;
      p_busy   = rec_busy;
      p_stuck  = scl_stuck;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int cyc, lat, dur, k;
   int s_scl, s_sda, s_done, s_gap, s_wbad, s_brise, s_srise;

   task automatic snap();
      s_scl   = n_scl_pulse;
      s_sda   = n_sda_pulse;
      s_done  = n_done;
      s_gap   = n_busy_gap;
      s_wbad  = n_w_bad;
      s_brise = n_busy_rise;
      s_srise = n_stuck_rise;
   endtask

   initial begin
      // Reset state.
      #1 rst_n = 1'b0;
      tick(4);
      chk("rst_oe", {30'd0, bus_if.scl_oe, bus_if.sda_oe}, 0);
      chk("rst_tmr_en", 32'(bus_if.tmr_en), 0);
      chk("rst_tmr_dly", 32'(bus_if.tmr_dly), 0);
      chk("rst_flags", {28'd0, scl_stuck, rec_busy, rec_done, rec_fail}, 0);
      chk("rst_pulse_cnt", 32'(pulse_cnt), 0);
      chk("rst_clk_en", 32'(bus_if.tmr_clk_en), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Tick period.
      cyc = 0;
      while (!bus_if.tmr_clk_en && cyc < 200) begin tick(1); cyc++; end
      tick(1);
      lat = 1;
      while (!bus_if.tmr_clk_en && lat < 200) begin tick(1); lat++; end
      chk("tick_period", 32'(lat), TICK);

      // SCL held low: stuck flag after the stuck window, never driven.
      snap();
      dur = int'($urandom_range(1500, 2250));
      scl_ext = 1'b0;
      lat = 0;
      while (!scl_stuck && lat < dur) begin tick(1); lat++; end
      chk("stuck_seen", 32'(scl_stuck), 1);
      chk("stuck_latency_ok",
          32'(lat >= int'(STUCK * TICK) && lat <= int'((STUCK + 1) * TICK + 8)), 1);
      if (dur > lat) tick(dur - lat);
      chk("stuck_held", 32'(scl_stuck), 1);
      scl_ext = 1'b1;
      tick(3);
      chk("stuck_cleared", 32'(scl_stuck), 0);
      chk("stuck_no_drive", 32'(n_scl_pulse - s_scl), 0);
      tick(10);

      // Short SDA low with SCL high (START): nothing happens.
      snap();
      dur = int'($urandom_range(100, 1000));
      sda_ext = 1'b0;
      tick(dur);
      sda_ext = 1'b1;
      tick(2000);
      chk("start_no_scl", 32'(n_scl_pulse - s_scl), 0);
      chk("start_no_sda", 32'(n_sda_pulse - s_sda), 0);
      chk("start_no_busy", 32'(n_busy_rise - s_brise), 0);
      chk("start_no_stuck", 32'(n_stuck_rise - s_srise), 0);
      chk("start_no_fail", 32'(rec_fail), 0);

      // SDA stuck, released after k pulses: k pulses plus one STOP low.
      snap();
      k = int'($urandom_range(1, 8));
      sda_ext = 1'b0;
      cyc = 0;
      while (!(rec_busy && pulse_cnt == 4'(k) && !bus_if.scl_oe) && cyc < 10000) begin
         tick(1);
         cyc++;
      end
      chk("rec_reach_k", 32'(cyc < 10000), 1);
      sda_ext = 1'b1;
      cyc = 0;
      while (rec_busy && cyc < 3000) begin tick(1); cyc++; end
      tick(5);
      chk("rec_idle", 32'(rec_busy), 0);
      chk("rec_scl_lows", 32'(n_scl_pulse - s_scl), 32'(k + 1));
      chk("rec_sda_lows", 32'(n_sda_pulse - s_sda), 1);
      chk("rec_done_once", 32'(n_done - s_done), 1);
      chk("rec_pulse_cnt", 32'(pulse_cnt), 32'(k));
      chk("rec_no_fail", 32'(rec_fail), 0);
      chk("rec_half_width", 32'(n_w_bad - s_wbad), 0);
      chk("rec_restarts", 32'(n_busy_gap - s_gap), 32'(2 * k + 3));
      chk("rec_released", {30'd0, bus_if.scl_oe, bus_if.sda_oe}, 0);

      // SDA stuck for good: 9 pulses then sticky fail.
      snap();
      sda_ext = 1'b0;
      cyc = 0;
      while (!rec_fail && cyc < 12000) begin tick(1); cyc++; end
      chk("fail_seen", 32'(rec_fail), 1);
      chk("fail_busy", 32'(rec_busy), 0);
      chk("fail_released", {30'd0, bus_if.scl_oe, bus_if.sda_oe}, 0);
      chk("fail_pulse_cnt", 32'(pulse_cnt), 9);
      chk("fail_scl_lows", 32'(n_scl_pulse - s_scl), 9);
      chk("fail_restarts", 32'(n_busy_gap - s_gap), 18);
      chk("fail_no_stop", 32'(n_sda_pulse - s_sda), 0);
      chk("fail_no_done", 32'(n_done - s_done), 0);
      chk("fail_half_width", 32'(n_w_bad - s_wbad), 0);
      snap();
      tick(3000);
      chk("fail_sticky", 32'(rec_fail), 1);
      chk("fail_blocks", 32'(n_busy_rise - s_brise), 0);
      clr_fail = 1'b1;
      tick(1);
      clr_fail = 1'b0;
      chk("fail_cleared", 32'(rec_fail), 0);
      cyc = 0;
      while (!rec_busy && cyc < 3000) begin tick(1); cyc++; end
      chk("fail_restart", 32'(rec_busy), 1);
      sda_ext = 1'b1;
      snap();
      cyc = 0;
      while (rec_busy && cyc < 3000) begin tick(1); cyc++; end
      tick(3);
      chk("restart_done", 32'(n_done - s_done), 1);
      chk("restart_pulse_cnt", 32'(pulse_cnt), 1);

      // Clear held across FAIL entry: the set still lands for one cycle.
      sda_ext = 1'b0;
      cyc = 0;
      while (!(rec_busy && pulse_cnt == 4'd9) && cyc < 12000) begin tick(1); cyc++; end
      clr_fail = 1'b1;
      cyc = 0;
      while (!rec_fail && cyc < 1000) begin tick(1); cyc++; end
      chk("race_set_wins", 32'(rec_fail), 1);
      tick(1);
      chk("race_then_clear", 32'(rec_fail), 0);
      clr_fail = 1'b0;
      sda_ext  = 1'b1;
      tick(100);

      // Asynchronous reset during P_LO.
      sda_ext = 1'b0;
      cyc = 0;
      while (!bus_if.scl_oe && cyc < 3000) begin tick(1); cyc++; end
      tick(5);
      #1 rst_n = 1'b0;
      #1 chk("arst_scl_rel", 32'(bus_if.scl_oe), 0);
      sda_ext = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      chk("arst_pulse_cnt", 32'(pulse_cnt), 0);
      chk("arst_idle", {29'd0, rec_busy, bus_if.tmr_en, bus_if.scl_oe}, 0);
      chk("arst_dly", 32'(bus_if.tmr_dly), 0);

      // Monitor disable during P_HI.
      sda_ext = 1'b0;
      cyc = 0;
      while (!(rec_busy && pulse_cnt == 4'd2 && !bus_if.scl_oe) && cyc < 6000) begin
         tick(1);
         cyc++;
      end
      tick(10);
      mon_en = 1'b0;
      tick(1);
      chk("mon_off_busy", 32'(rec_busy), 0);
      chk("mon_off_lines", {30'd0, bus_if.scl_oe, bus_if.sda_oe}, 0);
      chk("mon_off_tmr", {31'd0, bus_if.tmr_en}, 0);
      chk("mon_off_dly", 32'(bus_if.tmr_dly), 0);
      chk("mon_off_fail", 32'(rec_fail), 0);
      sda_ext = 1'b1;
      mon_en  = 1'b1;
      tick(20);

      chk("restart_low_one_clk", 32'(n_en_long), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
